// File: rtl/blur_frame_uart_tx_if.sv
// Signal bundle between the blur pipeline sink and whatever drives/observes it.
// The design takes the slave view; a driver or bench takes the master view.
interface blur_frame_uart_tx_if;
   logic       start;
   logic [7:0] pixel_in;
   logic       pixel_in_valid;
   logic       frame_done;
   logic       uart_txd;
   logic       busy;
   logic       frame_sent;
   logic       overflow;

   modport master (
      output start, pixel_in, pixel_in_valid, frame_done,
      input  uart_txd, busy, frame_sent, overflow
   );

   modport slave (
      input  start, pixel_in, pixel_in_valid, frame_done,
      output uart_txd, busy, frame_sent, overflow
   );
endinterface

// File: rtl/blur_frame_uart_tx.sv
// Captures one blurred frame into a BRAM frame buffer, then streams it to the host
// over UART 8N1 (optional A5/5A sync header), back-to-back with no idle gaps.
module blur_frame_uart_tx #(
   parameter int WIDTH     = 128,
   parameter int HEIGHT    = 128,
   parameter int CLK_FREQ  = 100000000,
   parameter int BAUD      = 115200,
   parameter bit HEADER_EN = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   blur_frame_uart_tx_if.slave  bus
);
   localparam int TOTAL        = WIDTH * HEIGHT;
   localparam int AW           = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam int CW           = $clog2(TOTAL + 1);
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int BW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] LAST_PIX  = CW'(TOTAL - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_HEADER,
      ST_SEND
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] wr_addr_q, wr_addr_d;
   logic [CW-1:0] rd_addr_q, rd_addr_d;
   logic [CW-1:0] tx_len_q, tx_len_d;
   logic [BW-1:0] baud_cnt_q, baud_cnt_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          txd_q, txd_d;
   logic          hdr_sel_q, hdr_sel_d;
   logic          overflow_q, overflow_d;
   logic          frame_sent_q, frame_sent_d;

   logic [7:0]    mem [TOTAL];
   logic [7:0]    rd_data_q;
   logic          mem_we;
   logic [7:0]    tx_byte;
   logic          bit_end;

   // NOTE: the frame buffer and its read register carry no reset so they map onto BRAM.
   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_addr_q[AW-1:0]] <= bus.pixel_in;
      rd_data_q <= mem[rd_addr_q[AW-1:0]];
   end

   // The outgoing byte is latched at the end of its start bit, long after the read settles.
   assign tx_byte = (state_q == ST_HEADER) ? (hdr_sel_q ? 8'h5A : 8'hA5) : rd_data_q;
   assign bit_end = (baud_cnt_q == BAUD_LAST);

   always_comb begin
      // NOTE: every _d takes its hold value first, so no path through the case infers a latch.
      state_d      = state_q;
      wr_addr_d    = wr_addr_q;
      rd_addr_d    = rd_addr_q;
      tx_len_d     = tx_len_q;
      baud_cnt_d   = baud_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      txd_d        = txd_q;
      hdr_sel_d    = hdr_sel_q;
      overflow_d   = overflow_q;
      frame_sent_d = 1'b0;
      mem_we       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d    = ST_CAPTURE;
               wr_addr_d  = '0;
               rd_addr_d  = '0;
               overflow_d = 1'b0;
            end
         end

         ST_CAPTURE: begin
            mem_we = bus.pixel_in_valid;
            if (bus.pixel_in_valid) wr_addr_d = wr_addr_q + CW'(1);
            // A pixel coinciding with frame_done is written and counted before exit.
            if (bus.frame_done || (bus.pixel_in_valid && wr_addr_q == LAST_PIX)) begin
               tx_len_d = wr_addr_d;
               if (wr_addr_d == '0) begin
                  state_d      = ST_IDLE;
                  frame_sent_d = 1'b1;
               end else begin
                  state_d    = HEADER_EN ? ST_HEADER : ST_SEND;
                  txd_d      = 1'b0;
                  baud_cnt_d = '0;
                  bit_cnt_d  = '0;
                  hdr_sel_d  = 1'b0;
               end
            end
         end

         ST_HEADER, ST_SEND: begin
            if (bus.pixel_in_valid) overflow_d = 1'b1;
            if (!bit_end) begin
               baud_cnt_d = baud_cnt_q + BW'(1);
            end else begin
               baud_cnt_d = '0;
               bit_cnt_d  = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd0) begin
                  shift_d = tx_byte;
                  txd_d   = tx_byte[0];
                  if (state_q == ST_SEND) rd_addr_d = rd_addr_q + CW'(1);
               end else if (bit_cnt_q < 4'd8) begin
                  txd_d = shift_q[bit_cnt_q[2:0]];
               end else if (bit_cnt_q == 4'd8) begin
                  txd_d = 1'b1;
               end else begin
                  // End of stop bit: chain the next start bit or finish the frame.
                  bit_cnt_d = '0;
                  if (state_q == ST_HEADER) begin
                     if (hdr_sel_q) state_d = ST_SEND;
                     hdr_sel_d = 1'b1;
                     txd_d     = 1'b0;
                  end else if (rd_addr_q == tx_len_q) begin
                     state_d      = ST_IDLE;
                     frame_sent_d = 1'b1;
                     txd_d        = 1'b1;
                  end else begin
                     txd_d = 1'b0;
                  end
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         wr_addr_q    <= '0;
         rd_addr_q    <= '0;
         tx_len_q     <= '0;
         baud_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         txd_q        <= 1'b1;
         hdr_sel_q    <= 1'b0;
         overflow_q   <= 1'b0;
         frame_sent_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_addr_q    <= wr_addr_d;
         rd_addr_q    <= rd_addr_d;
         tx_len_q     <= tx_len_d;
         baud_cnt_q   <= baud_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         txd_q        <= txd_d;
         hdr_sel_q    <= hdr_sel_d;
         overflow_q   <= overflow_d;
         frame_sent_q <= frame_sent_d;
      end
   end

   assign bus.uart_txd   = txd_q;
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.frame_sent = frame_sent_q;
   assign bus.overflow   = overflow_q;

endmodule
